tla_cap_sequencer: RTL and testbench
====================================

TLA_CAP_SEQUENCER -- requirements
Module: tla_cap_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the post-trigger length and counter.
REQ-002 SHALL have parameter TMO_CYC, default 1000000, the cycles allowed in WAIT_CMPT before timeout; legal range 1..2^24-1.
REQ-003 SHALL have port Ga_clk50  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port Gc_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port Ga_arm  in  1  single-cycle arm request from the host.
REQ-006 SHALL have port Ga_abort  in  1  single-cycle abort request.
REQ-007 SHALL have port Ga_cap_trig  in  1  single-cycle capture-trigger pulse, already synchronised to Ga_clk50.
REQ-008 SHALL have port Ga_cap_cmpt  in  1  single-cycle capture-complete pulse, already synchronised to Ga_clk50.
REQ-009 SHALL have port Ga_post_len  in  CNT_W  number of post-trigger sample cycles.
REQ-010 SHALL have port Ga_cap_en  out  1  sample-write enable to the capture buffer.
REQ-011 SHALL have port Ga_busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port Ga_done  out  1  one-cycle pulse when a capture completes.
REQ-013 SHALL have port Ga_timeout  out  1  one-cycle pulse when WAIT_CMPT expires.
REQ-014 SHALL have port Ga_state  out  3  state code: IDLE=0, ARMED=1, POST=2, WAIT_CMPT=3, DONE=4.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 In IDLE, Ga_arm=1 SHALL move the block to ARMED next cycle; Ga_cap_trig and Ga_cap_cmpt SHALL be ignored in IDLE.
REQ-017 Ga_cap_en SHALL be 1 exactly while the state is ARMED or POST, and 0 otherwise.
REQ-018 In ARMED, Ga_cap_trig at cycle t SHALL sample Ga_post_len into the down-counter; the block SHALL be in POST for cycles t+1..t+N and in WAIT_CMPT at t+N+1 (N = sampled length).
REQ-019 If N=0, the block SHALL go from ARMED directly to WAIT_CMPT at t+1.
REQ-020 Ga_cap_trig pulses in POST, WAIT_CMPT and DONE SHALL be ignored; Ga_post_len changes after sampling SHALL have no effect.
REQ-021 On entry to WAIT_CMPT, the timeout counter SHALL load TMO_CYC-1. Ga_cap_cmpt in WAIT_CMPT at cycle k SHALL move the block to DONE at k+1, with Ga_done=1 for that one cycle.
REQ-022 If the timeout counter is 0 with no Ga_cap_cmpt, the next cycle SHALL be IDLE with Ga_timeout=1 for one cycle; if Ga_cap_cmpt coincides with expiry, cmpt SHALL win (DONE, no timeout).
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE (see REQ-029).
REQ-024 Ga_abort in any non-IDLE state SHALL force IDLE next cycle with no done or timeout pulse, overriding trig, cmpt and expiry in the same cycle.
REQ-025 Ga_arm while not in IDLE SHALL be ignored; simultaneous Ga_arm and Ga_abort in IDLE SHALL leave the block in IDLE.
REQ-026 Counters SHALL saturate at 0, never wrap; the timeout counter SHALL be 24 bits.

Reset
REQ-027 Gc_rst=1 SHALL, at the next edge, set state IDLE, clear both counters, and drive Ga_cap_en, Ga_busy, Ga_done and Ga_timeout to 0 and Ga_state to 0, including mid-capture.
REQ-028 No pulse output SHALL assert in the first cycle after reset release.

Configuration
REQ-029 Macro TLA_CAP_AUTOARM_EN: when defined, DONE SHALL go to ARMED (continuous capture, Ga_cap_en=1 from the next cycle); when undefined, DONE SHALL go to IDLE. Timeout and abort SHALL always go to IDLE.

Structure
REQ-030 Package tla_cap_pkg SHALL hold the state enum/encoding, the 3-bit state width and the 24-bit timeout counter width.
REQ-031 Sub-module tla_down_cnt (loadable, saturating down-counter with a zero flag, parameterised width) SHALL be used twice, for the post count and for the timeout.

Verification
REQ-032 Arm at cycle 0, trig at 20 with post_len=8 -> Ga_cap_en high cycles 1..28, state 3 at 29; cmpt at 33 -> Ga_done=1 at 34, IDLE at 35.
REQ-033 TMO_CYC=16, trig with post_len=0, no cmpt -> WAIT_CMPT for 16 cycles, then one Ga_timeout pulse with state IDLE, no Ga_done.
REQ-034 Abort during POST with 5 counts left -> IDLE next cycle, Ga_cap_en=0, no pulses; a later trig is ignored.
REQ-035 TMO_CYC=4, cmpt on the expiry cycle -> Ga_done pulse, Ga_timeout stays 0.
REQ-036 Gc_rst asserted in WAIT_CMPT -> all outputs 0 next cycle; arm after release restarts normally.
REQ-037 With TLA_CAP_AUTOARM_EN, two trig/cmpt pairs after one arm -> two Ga_done pulses, and state 1 after each DONE.

Source files
------------

// File: rtl/tla_cap_pkg.sv
// Shared types and widths for the capture sequencer: state encoding,
// state-code width and the fixed timeout-counter width.
package tla_cap_pkg;

  localparam int STATE_W = 3;
  localparam int TMO_W   = 24;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_POST      = 3'd2,
    ST_WAIT_CMPT = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_e;

  // The capture buffer is written while waiting for the trigger and during
  // the post-trigger window.
  function automatic logic isCapturing(input cap_state_e s);
    return (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/tla_down_cnt.sv
// Loadable down-counter that stops at zero instead of wrapping, with a
// flag telling the owner that the count has run out.
module tla_down_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Load wins over decrement; decrementing an empty counter leaves it at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Count register, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tla_cap_sequencer.sv
// Capture sequencer for the logic analyser: arm, wait for trigger, record a
// post-trigger window, then wait for the buffer to report completion with a
// timeout. Every output is driven from a flop.
// Build option: define TLA_CAP_AUTOARM_EN to re-arm straight after DONE for
// continuous capture; otherwise DONE returns to IDLE.
module tla_cap_sequencer
  import tla_cap_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TMO_CYC = 1000000
) (
  input  logic                Ga_clk50,
  input  logic                Gc_rst,
  input  logic                Ga_arm,
  input  logic                Ga_abort,
  input  logic                Ga_cap_trig,
  input  logic                Ga_cap_cmpt,
  input  logic [CNT_W-1:0]    Ga_post_len,
  output logic                Ga_cap_en,
  output logic                Ga_busy,
  output logic                Ga_done,
  output logic                Ga_timeout,
  output logic [STATE_W-1:0]  Ga_state
);

  // The timeout counter counts down to zero, so the last WAIT_CMPT cycle is
  // the one where it reads zero: loading TMO_CYC-1 gives TMO_CYC cycles.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);

  cap_state_e state_q, state_d;

  logic             capEn_q, busy_q, done_q, timeout_q;
  logic             timeout_d;

  logic             postLoad, postDec, postZero;
  logic [CNT_W-1:0] postLoadVal;
  logic             tmoLoad, tmoDec, tmoZero;

  // Post-trigger counter holds the number of POST cycles still to run after
  // the current one, hence it is loaded with N-1.
  tla_down_cnt #(.W(CNT_W)) uPostCnt (
    .clk_i      (Ga_clk50),
    .rst_i      (Gc_rst),
    .load_i     (postLoad),
    .load_val_i (postLoadVal),
    .dec_i      (postDec),
    .zero_o     (postZero)
  );

  tla_down_cnt #(.W(TMO_W)) uTmoCnt (
    .clk_i      (Ga_clk50),
    .rst_i      (Gc_rst),
    .load_i     (tmoLoad),
    .load_val_i (TMO_LOAD),
    .dec_i      (tmoDec),
    .zero_o     (tmoZero)
  );

  // Next-state and counter control; abort has top priority in every busy state.
  always_comb begin
    state_d     = state_q;
    timeout_d   = 1'b0;
    postLoad    = 1'b0;
    postLoadVal = '0;
    postDec     = 1'b0;
    tmoLoad     = 1'b0;
    tmoDec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Ga_arm && !Ga_abort) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (Ga_abort) begin
          state_d = ST_IDLE;
        end else if (Ga_cap_trig) begin
          postLoad = 1'b1;
          if (Ga_post_len == '0) begin
            state_d = ST_WAIT_CMPT;
            tmoLoad = 1'b1;
          end else begin
            postLoadVal = Ga_post_len - CNT_W'(1);
            state_d     = ST_POST;
          end
        end
      end

      ST_POST: begin
        if (Ga_abort) begin
          state_d = ST_IDLE;
        end else if (postZero) begin
          state_d = ST_WAIT_CMPT;
          tmoLoad = 1'b1;
        end else begin
          postDec = 1'b1;
        end
      end

      ST_WAIT_CMPT: begin
        if (Ga_abort) begin
          state_d = ST_IDLE;
        end else if (Ga_cap_cmpt) begin
          state_d = ST_DONE;
        end else if (tmoZero) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          tmoDec = 1'b1;
        end
      end

      ST_DONE: begin
        if (Ga_abort) begin
          state_d = ST_IDLE;
        end else begin
`ifdef TLA_CAP_AUTOARM_EN
          state_d = ST_ARMED;
`else
          state_d = ST_IDLE;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output flops; outputs are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge Ga_clk50) begin
    if (Gc_rst) begin
      state_q   <= ST_IDLE;
      capEn_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      capEn_q   <= isCapturing(state_d);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      timeout_q <= timeout_d;
    end
  end

  assign Ga_cap_en  = capEn_q;
  assign Ga_busy    = busy_q;
  assign Ga_done    = done_q;
  assign Ga_timeout = timeout_q;
  assign Ga_state   = state_q;

endmodule

// File: tb/tb_tla_cap_sequencer.sv
// Scoreboard bench for tla_cap_sequencer. Directed sequences push expected
// output snapshots keyed by cycle; a negedge monitor pops and compares them
// and flags any done/timeout pulse nobody expected.
module tb_tla_cap_sequencer;

  localparam int CNT_W   = 16;
  localparam int TMO_CYC = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic             trig = 1'b0;
  logic             cmpt = 1'b0;
  logic [CNT_W-1:0] postLen = '0;

  logic             capEn, busy, done, timeout;
  logic [2:0]       state;

  int cyc    = 0;
  int base   = 0;
  int checks = 0;
  int errors = 0;
  bit monMatched;
  string testName = "init";

  int         expCyc[$];
  logic [6:0] expVec[$];
  string      expName[$];

  tla_cap_sequencer #(.CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
    .Ga_clk50    (clk),
    .Gc_rst      (rst),
    .Ga_arm      (arm),
    .Ga_abort    (abort),
    .Ga_cap_trig (trig),
    .Ga_cap_cmpt (cmpt),
    .Ga_post_len (postLen),
    .Ga_cap_en   (capEn),
    .Ga_busy     (busy),
    .Ga_done     (done),
    .Ga_timeout  (timeout),
    .Ga_state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic a, input logic ab, input logic t,
                               input logic c, input logic [CNT_W-1:0] len);
    arm = a; abort = ab; trig = t; cmpt = c; postLen = len;
    tick();
    arm = 1'b0; abort = 1'b0; trig = 1'b0; cmpt = 1'b0;
  endtask

  task automatic startTest(input string name);
    testName = name;
    base = cyc;
  endtask

  task automatic pushExp(input int rel, input logic [2:0] st, input logic ce,
                         input logic d, input logic to);
    expCyc.push_back(base + rel);
    expVec.push_back({st, ce, (st != 3'd0), d, to});
    expName.push_back($sformatf("%s_c%0d", testName, rel));
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {state, capEn, busy, done, timeout};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d cap_en=%b busy=%b done=%b timeout=%b, expected state=%0d cap_en=%b busy=%b done=%b timeout=%b",
               name, act[6:4], act[3], act[2], act[1], act[0],
               exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare every snapshot due this cycle, and catch stray pulses.
  always @(negedge clk) begin
    monMatched = 1'b0;
    while (expCyc.size() > 0 && expCyc[0] <= cyc) begin
      checkOutput(expName[0], expVec[0]);
      if (expCyc[0] == cyc) monMatched = 1'b1;
      void'(expCyc.pop_front());
      void'(expVec.pop_front());
      void'(expName.pop_front());
    end
    if (!monMatched && (done === 1'b1 || timeout === 1'b1)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_pulse at cycle %0d: done=%b timeout=%b, expected both 0",
               cyc, done, timeout);
    end
  end

  initial begin
    // Reset and IDLE behaviour
    tick();
    startTest("reset");
    pushExp(0, 3'd0, 0, 0, 0);
    tick();
    rst = 1'b0;
    startTest("idle");
    pushExp(1, 3'd0, 0, 0, 0);
    pushExp(2, 3'd0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 16'd5);
    applyStimulus(1, 1, 0, 0, 16'd5);
    idle(2);

    // Arm at 0, trig at 20 with length 8, cmpt at 33
    startTest("basic");
    pushExp(1,  3'd1, 1, 0, 0);
    pushExp(20, 3'd1, 1, 0, 0);
    pushExp(21, 3'd2, 1, 0, 0);
    pushExp(25, 3'd2, 1, 0, 0);
    pushExp(28, 3'd2, 1, 0, 0);
    pushExp(29, 3'd3, 0, 0, 0);
    pushExp(33, 3'd3, 0, 0, 0);
    pushExp(34, 3'd4, 0, 1, 0);
`ifdef TLA_CAP_AUTOARM_EN
    pushExp(35, 3'd1, 1, 0, 0);
`else
    pushExp(35, 3'd0, 0, 0, 0);
`endif
    pushExp(36, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd8);
    idle(19);
    applyStimulus(0, 0, 1, 0, 16'd8);
    idle(1);
    applyStimulus(0, 0, 0, 0, 16'd3);
    applyStimulus(0, 0, 1, 0, 16'd3);
    applyStimulus(1, 0, 0, 0, 16'd3);
    idle(8);
    applyStimulus(0, 0, 0, 1, 16'd3);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'd3);
    idle(2);

    // Zero-length window straight to WAIT_CMPT, then timeout after 16 cycles
    startTest("timeout");
    pushExp(5,  3'd1, 1, 0, 0);
    pushExp(6,  3'd3, 0, 0, 0);
    pushExp(21, 3'd3, 0, 0, 0);
    pushExp(22, 3'd0, 0, 0, 1);
    pushExp(23, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd0);
    idle(4);
    applyStimulus(0, 0, 1, 0, 16'd0);
    idle(20);

    // Abort in POST with five counts left; later trig/cmpt ignored
    startTest("abort");
    pushExp(3,  3'd2, 1, 0, 0);
    pushExp(7,  3'd2, 1, 0, 0);
    pushExp(8,  3'd0, 0, 0, 0);
    pushExp(11, 3'd0, 0, 0, 0);
    pushExp(13, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd10);
    idle(1);
    applyStimulus(0, 0, 1, 0, 16'd10);
    idle(4);
    applyStimulus(0, 1, 0, 0, 16'd10);
    idle(2);
    applyStimulus(0, 0, 1, 0, 16'd10);
    idle(1);
    applyStimulus(0, 0, 0, 1, 16'd10);
    idle(2);

    // Completion on the same cycle the timeout counter reaches zero
    startTest("cmpt_on_expiry");
    pushExp(3,  3'd2, 1, 0, 0);
    pushExp(4,  3'd3, 0, 0, 0);
    pushExp(19, 3'd3, 0, 0, 0);
    pushExp(20, 3'd4, 0, 1, 0);
`ifdef TLA_CAP_AUTOARM_EN
    pushExp(21, 3'd1, 1, 0, 0);
`else
    pushExp(21, 3'd0, 0, 0, 0);
`endif
    pushExp(22, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd2);
    applyStimulus(0, 0, 1, 0, 16'd2);
    idle(17);
    applyStimulus(0, 0, 0, 1, 16'd2);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'd2);
    idle(2);

    // Abort wins over a simultaneous cmpt in WAIT_CMPT
    startTest("abort_vs_cmpt");
    pushExp(2, 3'd3, 0, 0, 0);
    pushExp(3, 3'd3, 0, 0, 0);
    pushExp(4, 3'd0, 0, 0, 0);
    pushExp(5, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd0);
    applyStimulus(0, 0, 1, 0, 16'd0);
    idle(1);
    applyStimulus(0, 1, 1, 1, 16'd0);
    idle(3);

    // Reset in WAIT_CMPT, then a normal capture afterwards
    startTest("reset_in_wait");
    pushExp(2,  3'd2, 1, 0, 0);
    pushExp(3,  3'd3, 0, 0, 0);
    pushExp(5,  3'd3, 0, 0, 0);
    pushExp(6,  3'd0, 0, 0, 0);
    pushExp(7,  3'd0, 0, 0, 0);
    pushExp(8,  3'd1, 1, 0, 0);
    pushExp(10, 3'd3, 0, 0, 0);
    pushExp(12, 3'd4, 0, 1, 0);
`ifdef TLA_CAP_AUTOARM_EN
    pushExp(13, 3'd1, 1, 0, 0);
`else
    pushExp(13, 3'd0, 0, 0, 0);
`endif
    pushExp(14, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd1);
    applyStimulus(0, 0, 1, 0, 16'd1);
    idle(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(1);
    applyStimulus(1, 0, 0, 0, 16'd0);
    idle(1);
    applyStimulus(0, 0, 1, 0, 16'd0);
    idle(1);
    applyStimulus(0, 0, 0, 1, 16'd0);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'd0);
    idle(2);

    // Two trig/cmpt pairs after a single arm
    startTest("rearm");
    pushExp(3,  3'd2, 1, 0, 0);
    pushExp(4,  3'd3, 0, 0, 0);
    pushExp(7,  3'd4, 0, 1, 0);
`ifdef TLA_CAP_AUTOARM_EN
    pushExp(8,  3'd1, 1, 0, 0);
    pushExp(11, 3'd3, 0, 0, 0);
    pushExp(13, 3'd4, 0, 1, 0);
    pushExp(14, 3'd1, 1, 0, 0);
`else
    pushExp(8,  3'd0, 0, 0, 0);
    pushExp(11, 3'd0, 0, 0, 0);
    pushExp(13, 3'd0, 0, 0, 0);
    pushExp(14, 3'd0, 0, 0, 0);
`endif
    pushExp(15, 3'd0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'd1);
    idle(1);
    applyStimulus(0, 0, 1, 0, 16'd1);
    idle(3);
    applyStimulus(0, 0, 0, 1, 16'd1);
    idle(3);
    applyStimulus(0, 0, 1, 0, 16'd0);
    idle(1);
    applyStimulus(0, 0, 0, 1, 16'd0);
    idle(1);
    applyStimulus(0, 1, 0, 0, 16'd0);
    idle(3);

    checks++;
    if (expCyc.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expCyc.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
